// File: rtl/lcd_pkg.sv
// Shared LCD definitions: panel IDs, per-panel resolution, coordinate/colour
// types and the move-block FSM states.
package lcd_pkg;

  typedef logic [10:0] coord_t;
  typedef logic [23:0] rgb_t;

  typedef struct packed {
    coord_t h_disp;
    coord_t v_disp;
  } res_t;

  typedef enum logic {
    MV_WAIT,
    MV_RUN
  } mv_state_t;

  localparam logic [15:0] ID_4342 = 16'h4342;
  localparam logic [15:0] ID_7084 = 16'h7084;
  localparam logic [15:0] ID_7016 = 16'h7016;
  localparam logic [15:0] ID_1018 = 16'h1018;
  localparam logic [15:0] ID_4384 = 16'h4384;

  localparam rgb_t WHITE = 24'hFFFFFF;
  localparam rgb_t BLACK = 24'h000000;
  localparam rgb_t RED   = 24'hFF0000;
  localparam rgb_t GREEN = 24'h00FF00;
  localparam rgb_t BLUE  = 24'h0000FF;

  // Unknown panels fall back to the smallest (4.3") resolution.
  function automatic res_t res_of(input logic [15:0] id);
    res_t r;
    case (id)
      ID_7084, ID_4384: r = '{h_disp: 11'd800,  v_disp: 11'd480};
      ID_7016:          r = '{h_disp: 11'd1024, v_disp: 11'd600};
      ID_1018:          r = '{h_disp: 11'd1280, v_disp: 11'd800};
      default:          r = '{h_disp: 11'd480,  v_disp: 11'd272};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lcd_move_block_if.sv
// Pixel request/response link between lcd_dri (master) and a pixel source (slave).
interface lcd_move_block_if;
  import lcd_pkg::*;

  logic   data_req;
  coord_t lcd_xpos;
  coord_t lcd_ypos;
  rgb_t   lcd_data;

  modport master (output data_req, lcd_xpos, lcd_ypos, input lcd_data);
  modport slave  (input data_req, lcd_xpos, lcd_ypos, output lcd_data);
endinterface

// File: rtl/lcd_move_block_bounce_axis.sv
// One axis of the bouncing square: position, direction and edge clamping.
module lcd_bounce_axis
  import lcd_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   upd,
  input  coord_t limit,
  input  coord_t step,
  output coord_t pos
);

  coord_t      pos_q;
  logic        neg_q;
  logic [11:0] fwd;

  assign fwd = {1'b0, pos_q} + {1'b0, step};
  assign pos = pos_q;

  // An exact landing on either edge also reverses direction.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pos_q <= '0;
      neg_q <= 1'b0;
    end else if (upd) begin
      if (!neg_q) begin
        if (fwd >= {1'b0, limit}) begin
          pos_q <= limit;
          neg_q <= 1'b1;
        end else begin
          pos_q <= fwd[10:0];
        end
      end else begin
        if (pos_q <= step) begin
          pos_q <= '0;
          neg_q <= 1'b0;
        end else begin
          pos_q <= pos_q - step;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_move_block.sv
// Pixel source for lcd_dri drawing a square that bounces off the panel edges,
// stepping once every FRAME_DIV frame ends.
module lcd_move_block
  import lcd_pkg::*;
#(
  parameter int   BLK_SIZE  = 40,
  parameter int   STEP      = 2,
  parameter int   FRAME_DIV = 1,
  parameter rgb_t BG_COLOR  = 24'hFFFFFF,
  parameter rgb_t BLK_COLOR = 24'h0000FF
) (
  input  logic               clk_dri,
  input  logic               sys_rst,
  input  logic [15:0]        lcd_id,
  input  logic               move_en,
  lcd_move_block_if.slave    pix,
  output coord_t             blk_x,
  output coord_t             blk_y
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  res_t             res;
  logic [15:0]      id_q;
  logic             id_chg;
  logic             fe;
  mv_state_t        state, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             upd;
  logic             in_blk;
  rgb_t             lcd_data_p1;

  assign res    = res_of(lcd_id);
  assign id_chg = (lcd_id != id_q);
  assign fe     = pix.data_req && (pix.lcd_xpos == res.h_disp - 11'd1)
                               && (pix.lcd_ypos == res.v_disp - 11'd1);

  always_ff @(posedge clk_dri) begin
    if (sys_rst) begin
      state <= MV_WAIT;
      div_q <= '0;
      id_q  <= lcd_id;
    end else begin
      state <= state_d;
      div_q <= div_d;
      id_q  <= lcd_id;
    end
  end

  // A panel change restarts the animation and wins over a coincident frame end.
  always_comb begin
    state_d = state;
    div_d   = div_q;
    upd     = 1'b0;
    if (id_chg) begin
      state_d = MV_WAIT;
      div_d   = '0;
    end else if (fe) begin
      case (state)
        MV_WAIT: state_d = MV_RUN;
        MV_RUN: begin
          if (move_en) begin
            if (div_q == DIV_LAST) begin
              div_d = '0;
              upd   = 1'b1;
            end else begin
              div_d = div_q + 1'b1;
            end
          end
        end
        default: state_d = MV_WAIT;
      endcase
    end
  end

  lcd_bounce_axis u_axis_x (
    .clk   (clk_dri),
    .rst   (sys_rst),
    .clr   (id_chg),
    .upd   (upd),
    .limit (res.h_disp - coord_t'(BLK_SIZE)),
    .step  (coord_t'(STEP)),
    .pos   (blk_x)
  );

  lcd_bounce_axis u_axis_y (
    .clk   (clk_dri),
    .rst   (sys_rst),
    .clr   (id_chg),
    .upd   (upd),
    .limit (res.v_disp - coord_t'(BLK_SIZE)),
    .step  (coord_t'(STEP)),
    .pos   (blk_y)
  );

  assign in_blk = ({1'b0, pix.lcd_xpos} >= {1'b0, blk_x})
               && ({1'b0, pix.lcd_xpos} <  {1'b0, blk_x} + 12'(BLK_SIZE))
               && ({1'b0, pix.lcd_ypos} >= {1'b0, blk_y})
               && ({1'b0, pix.lcd_ypos} <  {1'b0, blk_y} + 12'(BLK_SIZE));

  // ---- p1: registered pixel ----
  always_ff @(posedge clk_dri) begin
    if (sys_rst)
      lcd_data_p1 <= '0;
    else if (!pix.data_req)
      lcd_data_p1 <= '0;
    else
      lcd_data_p1 <= in_blk ? BLK_COLOR : BG_COLOR;
  end

  assign pix.lcd_data = lcd_data_p1;

endmodule

// File: doc/lcd_move_block.md
Name: lcd_move_block

Overview:
- Pixel-data source for lcd_dri; takes the same slot as the colour-bar display generator, but renders an animated bouncing square instead.
- Answers lcd_dri pixel requests (data_req, lcd_xpos, lcd_ypos) with registered 24-bit RGB.
- Moves the square once per frame, or once every FRAME_DIV frames, bouncing off the panel edges.
- Panel resolution comes from lcd_id.

Parameters:
BLK_SIZE, 40, square edge length in pixels (1..271)
STEP, 2, pixels moved per update on each axis (1..BLK_SIZE)
FRAME_DIV, 1, frames per position update (>=1)
BG_COLOR, 24'hFFFFFF, background RGB
BLK_COLOR, 24'h0000FF, square fill RGB

Ports:
clk_dri  in  1  pixel-domain clock (same clock as lcd_dri)
sys_rst  in  1  synchronous reset, active-high
lcd_id  in  16  panel ID from lcd_id block; selects resolution
move_en  in  1  1 = animation runs; 0 = square frozen, still drawn
data_req  in  1  lcd_dri requests the pixel at (lcd_xpos, lcd_ypos)
lcd_xpos  in  11  0-based active column, valid while data_req=1
lcd_ypos  in  11  0-based active row, valid while data_req=1
lcd_data  out  24  RGB888 pixel, valid the cycle after data_req
blk_x  out  11  current square left edge (debug)
blk_y  out  11  current square top edge (debug)

Behaviour:
- Interface (already decided): one clock, clk_dri; reset sys_rst is synchronous and active-high.
- Resolution decode (H_DISP x V_DISP):
  - 16'h4342 -> 480x272
  - 16'h7084 -> 800x480
  - 16'h7016 -> 1024x600
  - 16'h1018 -> 1280x800
  - 16'h4384 -> 800x480
  - any other value -> 480x272
- Reset values: lcd_data=0, blk_x=0, blk_y=0, dir_x=+, dir_y=+, frame divider=0, FSM=WAIT.
- Pixel path, latency 1:
  - lcd_data <= (data_req==0) ? 0 : (pixel inside square ? BLK_COLOR : BG_COLOR).
  - Inside square means blk_x <= xpos < blk_x+BLK_SIZE and blk_y <= ypos < blk_y+BLK_SIZE.
  - Compare in 12 bits; no overflow.
- Frame end event (fe): data_req=1 and xpos==H_DISP-1 and ypos==V_DISP-1.
- FSM WAIT:
  - Holds the position.
  - Goes to RUN on the first fe, so motion only starts after a full frame has been scanned.
- FSM RUN, on each fe:
  - If move_en=0, nothing changes and the divider holds.
  - Otherwise the divider increments. When it reaches FRAME_DIV-1 it clears and both axes update; otherwise it keeps counting.
- Axis update, X shown; Y identical with V_DISP:
  - Moving +: if blk_x+STEP >= H_DISP-BLK_SIZE, set blk_x = H_DISP-BLK_SIZE and dir_x = -; else blk_x += STEP.
  - Moving -: if blk_x <= STEP, set blk_x = 0 and dir_x = +; else blk_x -= STEP.
  - An exact landing on an edge also flips direction.
- Position changes only at fe. The new position takes effect from the next frame's first pixel, so the square never tears mid-frame.
- lcd_id change, detected by comparing with a registered copy:
  - Next cycle: blk_x = blk_y = 0, dirs = +, divider = 0, FSM = WAIT.
  - Takes priority over a coincident fe.
- Reset mid-frame: all state returns to its reset values; pixels requested in that cycle are driven 0.
- data_req gaps (blanking) have no effect on state.

Decomposition:
- Shared package lcd_pkg:
  - Panel ID constants (ID_4342, ID_7084, ID_7016, ID_1018, ID_4384).
  - H_DISP/V_DISP per ID.
  - 11-bit coordinate type; 24-bit RGB type.
  - Standard colour constants. lcd_dri and lcd_disp reuse these.
- One sub-module, lcd_bounce_axis:
  - Holds one axis's position, direction and clamp logic.
  - Inputs: limit, step, update strobe, clear.
  - Instantiated twice (X with H_DISP, Y with V_DISP).

Test Plan:
- Reset, lcd_id=16'h4342, one full 480x272 scan with move_en=1:
  - Request (0,0) -> lcd_data=24'h0000FF one cycle later.
  - Request (40,0) -> 24'hFFFFFF.
  - data_req=0 -> 0.
  - Before fe: FSM in WAIT, blk_x=0, blk_y=0.
- Continue scanning frames with STEP=2, FRAME_DIV=1:
  - After 1st fe: FSM -> RUN, blk_x=0, blk_y=0.
  - After 2nd fe: blk_x=2, blk_y=2.
  - After 3rd fe: blk_x=4, blk_y=4.
  - New position visible from the first pixel of the next frame.
- Bounce, starting from blk_x=438, dir +, H_DISP=480:
  - Next fe -> blk_x=440, dir_x = -.
  - Following fe -> blk_x=438.
  - Mirror case at the left edge: blk_x=2, dir - -> 0, dir_x = +.
- move_en=0 for 3 frames:
  - blk_x/blk_y unchanged.
  - Re-assert -> resumes from the same position and direction.
- FRAME_DIV=4: position advances by exactly STEP once every 4 fe.
- lcd_id switched 16'h4342 -> 16'h7084 while blk_x=100:
  - Next cycle: blk_x=0, blk_y=0, FSM in WAIT.
  - Bounce limit becomes 800-40=760.
- sys_rst pulsed mid-scan: next cycle lcd_data=0, blk_x=0, blk_y=0, FSM in WAIT.
